// File: rtl/reg_writeback_queue_pkg.sv
// reg_writeback_queue_pkg: register ids and writeback entry layout shared by the queue and its FIFO.
package reg_writeback_queue_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0 = 5'd2;
  localparam logic [4:0] REG_A0 = 5'd4;
  localparam logic [4:0] REG_RA = 5'd31;
  typedef struct packed {
    logic is_link;
    logic [4:0] id;
    logic [31:0] value;
  } wb_entry_t;
  localparam int WB_ENTRY_W = $bits(wb_entry_t);
endpackage

// File: rtl/reg_writeback_queue_fifo.sv
// wb_fifo: circular buffer of writeback entries; exposes every slot plus a valid mask for hazard search.
module wb_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  wb_entry_t din,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0] valid,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr;
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clock) if (push) entries[wr_ptr] <= din;
  // a slot is live when its distance from the head is below the occupancy
  for (genvar k = 0; k < DEPTH; k++) begin : g_valid
    assign valid[k] = {1'b0, AW'(k) - rd_ptr} < count;
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: buffers writebacks, retires one per cycle to the reg file, flags pending sources.
// Optional WB_FORWARD_EN adds forwarding of the youngest queued value for rs/rt.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RA_ID = 31
) (
  input  logic clock,
  input  logic reset,
  input  logic wb_valid,
  output logic wb_ready,
  input  logic [4:0] wb_id,
  input  logic [31:0] wb_value,
  input  logic wb_link,
  input  logic [4:0] query_rs_id,
  input  logic [4:0] query_rt_id,
  output logic rs_pending,
  output logic rt_pending,
`ifdef WB_FORWARD_EN
  output logic rs_fwd_valid,
  output logic [31:0] rs_fwd_value,
  output logic rt_fwd_valid,
  output logic [31:0] rt_fwd_value,
`endif
  output logic control_reg_write,
  output logic [4:0] control_write_id,
  output logic [31:0] reg_write_value,
  output logic ra_write,
  output logic [31:0] ra_write_value
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t din, head;
  logic [DEPTH-1:0] valid;
  logic [AW-1:0] rd_ptr, idx;
  logic [AW:0] count;
  logic push, pop;
  assign wb_ready = count != (AW+1)'(DEPTH);
  assign pop = count != '0;
  // writes to the zero register complete the handshake but are dropped
  assign push = wb_valid & wb_ready & (wb_link | wb_id != REG_ZERO);
  assign din = '{is_link: wb_link, id: wb_link ? 5'(RA_ID) : wb_id, value: wb_value};
  assign head = entries[rd_ptr];
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .din(din),
    .entries(entries), .valid(valid), .rd_ptr(rd_ptr), .count(count)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      control_reg_write <= 1'b0;
      ra_write <= 1'b0;
      control_write_id <= '0;
      reg_write_value <= '0;
      ra_write_value <= '0;
    end else begin
      control_reg_write <= pop & ~head.is_link;
      ra_write <= pop & head.is_link;
      if (pop & ~head.is_link) begin
        control_write_id <= head.id;
        reg_write_value <= head.value;
      end
      if (pop & head.is_link) ra_write_value <= head.value;
    end
  end
  // scan oldest to newest so the last match seen is the youngest
  always_comb begin
    rs_pending = 1'b0;
    rt_pending = 1'b0;
    idx = '0;
`ifdef WB_FORWARD_EN
    rs_fwd_value = '0;
    rt_fwd_value = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (valid[idx] && query_rs_id != REG_ZERO && entries[idx].id == query_rs_id) begin
        rs_pending = 1'b1;
`ifdef WB_FORWARD_EN
        rs_fwd_value = entries[idx].value;
`endif
      end
      if (valid[idx] && query_rt_id != REG_ZERO && entries[idx].id == query_rt_id) begin
        rt_pending = 1'b1;
`ifdef WB_FORWARD_EN
        rt_fwd_value = entries[idx].value;
`endif
      end
    end
  end
`ifdef WB_FORWARD_EN
  assign rs_fwd_valid = rs_pending;
  assign rt_fwd_valid = rt_pending;
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed scenarios plus random traffic checked against a queue-based model.
module tb_reg_writeback_queue;
  import reg_writeback_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int RA_ID = 31;
  logic clock = 1'b0, reset = 1'b1;
  logic wb_valid = 1'b0, wb_ready, wb_link = 1'b0;
  logic [4:0] wb_id = '0, query_rs_id = '0, query_rt_id = '0, control_write_id;
  logic [31:0] wb_value = '0, reg_write_value, ra_write_value;
  logic rs_pending, rt_pending, control_reg_write, ra_write;
`ifdef WB_FORWARD_EN
  logic rs_fwd_valid, rt_fwd_valid;
  logic [31:0] rs_fwd_value, rt_fwd_value;
`endif
  reg_writeback_queue #(.DEPTH(DEPTH), .RA_ID(RA_ID)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_id(wb_id), .wb_value(wb_value), .wb_link(wb_link),
    .query_rs_id(query_rs_id), .query_rt_id(query_rt_id),
    .rs_pending(rs_pending), .rt_pending(rt_pending),
`ifdef WB_FORWARD_EN
    .rs_fwd_valid(rs_fwd_valid), .rs_fwd_value(rs_fwd_value),
    .rt_fwd_valid(rt_fwd_valid), .rt_fwd_value(rt_fwd_value),
`endif
    .control_reg_write(control_reg_write), .control_write_id(control_write_id),
    .reg_write_value(reg_write_value), .ra_write(ra_write), .ra_write_value(ra_write_value)
  );
  always #5 clock = ~clock;
  typedef struct {bit link; bit [4:0] id; bit [31:0] value;} ent_t;
  ent_t q[$];
  bit m_crw, m_ra;
  bit [4:0] m_id;
  bit [31:0] m_val, m_raval;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit pend(input bit [4:0] qid);
    if (qid == 0) return 1'b0;
    foreach (q[i]) if (q[i].id == qid) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit [31:0] fwd(input bit [4:0] qid);
    bit [31:0] v = 0;
    foreach (q[i]) if (qid != 0 && q[i].id == qid) v = q[i].value;
    return v;
  endfunction
  // drive one cycle from a negedge, check combinational outputs, advance model at posedge, check registers
  task automatic step(input bit rst, input bit v, input bit link, input bit [4:0] id,
                      input bit [31:0] val, input bit [4:0] rs, input bit [4:0] rt);
    ent_t e;
    bit can;
    reset = rst; wb_valid = v; wb_link = link; wb_id = id; wb_value = val;
    query_rs_id = rs; query_rt_id = rt;
    #1;
    check("wb_ready", wb_ready, q.size() != DEPTH);
    check("rs_pending", rs_pending, pend(rs));
    check("rt_pending", rt_pending, pend(rt));
`ifdef WB_FORWARD_EN
    check("rs_fwd_valid", rs_fwd_valid, pend(rs));
    check("rt_fwd_valid", rt_fwd_valid, pend(rt));
    if (pend(rs)) check("rs_fwd_value", rs_fwd_value, fwd(rs));
    if (pend(rt)) check("rt_fwd_value", rt_fwd_value, fwd(rt));
`endif
    @(posedge clock);
    if (rst) begin
      q.delete();
      {m_crw, m_ra, m_id, m_val, m_raval} = '0;
    end else begin
      can = q.size() != DEPTH;
      m_crw = 0; m_ra = 0;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.link) begin m_ra = 1; m_raval = e.value; end
        else begin m_crw = 1; m_id = e.id; m_val = e.value; end
      end
      if (v && can && (link || id != 0)) q.push_back('{link, link ? 5'(RA_ID) : id, val});
    end
    @(negedge clock);
    check("control_reg_write", control_reg_write, m_crw);
    check("control_write_id", control_write_id, m_id);
    check("reg_write_value", reg_write_value, m_val);
    check("ra_write", ra_write, m_ra);
    check("ra_write_value", ra_write_value, m_raval);
  endtask
  function automatic bit [4:0] pick_id();
    case ($urandom_range(0, 5))
      0: return REG_ZERO;
      1: return REG_V0;
      2: return REG_A0;
      3: return 5'd9;
      4: return REG_RA;
      default: return 5'($urandom);
    endcase
  endfunction
  initial begin
    @(negedge clock);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 5, 32'h1234, 5, 0);
    step(0, 0, 0, 0, 0, 5, 0);
    step(0, 1, 0, 0, 32'hffff, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 0, 5'(i + 10), 32'h100 + i, 5'(i + 10), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 32'h00400010, 31, 0);
    step(0, 1, 0, 8, 7, 31, 8);
    step(0, 0, 0, 0, 0, 31, 8);
    step(0, 0, 0, 0, 0, 31, 8);
    step(0, 1, 0, 9, 1, 0, 9);
    step(0, 1, 0, 9, 2, 0, 9);
    step(0, 0, 0, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 9);
    step(0, 1, 0, 3, 3, 3, 0);
    step(0, 1, 0, 4, 4, 3, 4);
    step(0, 1, 1, 6, 5, 31, 4);
    step(1, 1, 0, 7, 6, 31, 7);
    step(0, 0, 0, 0, 0, 31, 7);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           pick_id(), $urandom, pick_id(), pick_id());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
